// File: rtl/ethernetsystem_perf_counter_reader.sv
// ethernetsystem_perf_counter_reader
//
// Avalon-MM master that snapshots the EthernetSystem performance counter
// slave and streams the captured words out on a ready/valid interface.
//
// Sequence per accepted start:
//   [freeze write] -> for each section s, word w in {time lo, time hi, event}:
//   read 4s+w, wait for readdatavalid (or time out), push the word
//   -> [global-clear write] -> [resume write] -> done pulse.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start                        one-cycle snapshot request (ignored while busy)
//   freeze, clear, resume        options, sampled together with start
//   busy, done, error            status: busy span, completion pulse,
//                                sticky read-timeout flag
//   avm_*                        Avalon-MM master (word addressed)
//   st_data, st_valid, st_ready,
//   st_last                      snapshot word stream, st_last on final word
module ethernetsystem_perf_counter_reader #(
    parameter int unsigned NUM_SECTIONS = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        start,
    input  logic        freeze,
    input  logic        clear,
    input  logic        resume,
    output logic        busy,
    output logic        done,
    output logic        error,

    output logic [3:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic        avm_begintransfer,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,

    output logic [31:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_last
);

    typedef enum logic [2:0] {
        StIdle,
        StFreeze,
        StRead,
        StWait,
        StPush,
        StClear,
        StResume,
        StDone
    } state_e;

    localparam int unsigned TmoW        = 16;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
    localparam logic [1:0] LastSec      = 2'(NUM_SECTIONS - 1);
    localparam logic [31:0] TimeoutWord = 32'hDEAD_BEEF;

    // Control slave register map (word addresses)
    localparam logic [3:0] AddrCtrl0   = 4'd0;  // section 0 stop / global reset
    localparam logic [3:0] AddrCtrl1   = 4'd1;  // section 0 start
    localparam logic [31:0] DataStop   = 32'd0;
    localparam logic [31:0] DataGlbRst = 32'd1;
    localparam logic [31:0] DataStart  = 32'd0;

    state_e          state_q, state_d;
    logic [1:0]      sec_q, sec_d;       // section index s
    logic [1:0]      wrd_q, wrd_d;       // word within section w (0..2)
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [31:0]     data_q, data_d;
    logic            error_q, error_d;
    logic            clear_q, clear_d;
    logic            resume_q, resume_d;
    // Set while a request has been presented but stalled by waitrequest, so
    // begintransfer only marks the first request cycle.
    logic            began_q, began_d;

    logic            req_read;
    logic            req_write;
    logic [3:0]      req_addr;
    logic [31:0]     req_data;
    logic            last_word;

    assign last_word = (sec_q == LastSec) && (wrd_q == 2'd2);

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        wrd_d     = wrd_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        error_d   = error_q;
        clear_d   = clear_q;
        resume_d  = resume_q;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'd0;
        req_data  = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clear_d  = clear;
                    resume_d = resume;
                    error_d  = 1'b0;
                    sec_d    = 2'd0;
                    wrd_d    = 2'd0;
                    state_d  = freeze ? StFreeze : StRead;
                end
            end

            // Stopping section 0 disables counting globally.
            StFreeze: begin
                req_write = 1'b1;
                req_addr  = AddrCtrl0;
                req_data  = DataStop;
                if (!avm_waitrequest) begin
                    state_d = StRead;
                end
            end

            StRead: begin
                req_read = 1'b1;
                req_addr = {sec_q, wrd_q};
                if (!avm_waitrequest) begin
                    tmo_d   = '0;
                    state_d = StWait;
                end
            end

            // tmo_q counts completed wait cycles; fire on the TIMEOUT-th cycle.
            StWait: begin
                if (avm_readdatavalid) begin
                    data_d  = avm_readdata;
                    state_d = StPush;
                end else if (tmo_q == TmoLast) begin
                    error_d = 1'b1;
                    data_d  = TimeoutWord;
                    state_d = StPush;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end

            StPush: begin
                if (st_ready) begin
                    if (wrd_q == 2'd2) begin
                        wrd_d = 2'd0;
                        sec_d = sec_q + 2'd1;
                    end else begin
                        wrd_d = wrd_q + 2'd1;
                    end
                    if (!last_word) begin
                        state_d = StRead;
                    end else if (clear_q) begin
                        state_d = StClear;
                    end else if (resume_q) begin
                        state_d = StResume;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            // Global reset zeroes every counter and enable.
            StClear: begin
                req_write = 1'b1;
                req_addr  = AddrCtrl0;
                req_data  = DataGlbRst;
                if (!avm_waitrequest) begin
                    state_d = resume_q ? StResume : StDone;
                end
            end

            // Restarting section 0 also bumps event_counter_0 by one.
            StResume: begin
                req_write = 1'b1;
                req_addr  = AddrCtrl1;
                req_data  = DataStart;
                if (!avm_waitrequest) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign began_d = (req_read || req_write) && avm_waitrequest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            sec_q    <= 2'd0;
            wrd_q    <= 2'd0;
            tmo_q    <= '0;
            data_q   <= 32'd0;
            error_q  <= 1'b0;
            clear_q  <= 1'b0;
            resume_q <= 1'b0;
            began_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec_d;
            wrd_q    <= wrd_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            error_q  <= error_d;
            clear_q  <= clear_d;
            resume_q <= resume_d;
            began_q  <= began_d;
        end
    end

    // Request outputs are decoded from registered state only, so they stay
    // stable for the whole stalled transfer.
    always_comb begin
        avm_read          = req_read;
        avm_write         = req_write;
        avm_address       = req_addr;
        avm_writedata     = req_write ? req_data : 32'd0;
        avm_begintransfer = (req_read || req_write) && !began_q;

        st_data  = data_q;
        st_valid = (state_q == StPush);
        st_last  = (state_q == StPush) && last_word;

        busy  = (state_q != StIdle) && (state_q != StDone);
        done  = (state_q == StDone);
        error = error_q;
    end

endmodule
